spi_cmd_arbiter: RTL and testbench

Round-robin arbiter that shares one SPI master command port between two requesters (e.g. a config sequencer and a host bridge). It accepts one command at a time from a requester and forwards it to the master. It tracks the transaction to completion (write finished, or read data returned) and routes completion, read data and timeout error back to the owner. It sits directly upstream of the SPI master's `cmd_in`/`cmd_vld`/`cmd_rdy`/`read_vld`/`read_data` interface.

---
 rtl/spi_cmd_arbiter.sv | 118 +++++++++++
 tb/tb_spi_cmd_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_arbiter.sv
// spi_cmd_arbiter: round-robin sharing of one SPI master command port between two requesters,
// tracking each transaction to completion and routing done/err/read data back to its owner.
module spi_cmd_arbiter #(
  parameter int CMD_WIDTH   = 12,
  parameter int READ_WIDTH  = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CMD_WIDTH-1:0]  r0_cmd,
  input  logic                  r0_vld,
  output logic                  r0_rdy,
  output logic                  r0_done,
  output logic                  r0_err,
  output logic [READ_WIDTH-1:0] r0_rd_data,
  input  logic [CMD_WIDTH-1:0]  r1_cmd,
  input  logic                  r1_vld,
  output logic                  r1_rdy,
  output logic                  r1_done,
  output logic                  r1_err,
  output logic [READ_WIDTH-1:0] r1_rd_data,
  output logic [CMD_WIDTH-1:0]  m_cmd_data,
  output logic                  m_cmd_vld,
  input  logic                  m_cmd_rdy,
  input  logic                  m_read_vld,
  input  logic [READ_WIDTH-1:0] m_read_data,
  output logic                  busy,
  output logic                  owner
);
  localparam int CW = $clog2(TIMEOUT_CYC);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, DONE} state_e;
  state_e                state_q, state_d;
  logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
  logic [READ_WIDTH-1:0] rdata_q, rdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  owner_q, owner_d, is_read_q, is_read_d, err_q, err_d;
  logic                  grant, exit_c, tmo;
  // owner_q doubles as last_grant: it only changes on a grant
  assign grant  = (r0_vld & r1_vld) ? ~owner_q : r1_vld;
  assign exit_c = is_read_q ? m_read_vld : m_cmd_rdy;
  assign tmo    = cnt_q == CW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      owner_q   <= 1'b1;
      is_read_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      is_read_q <= is_read_d;
      err_q     <= err_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    is_read_d = is_read_q;
    err_d     = err_q;
    case (state_q)
      IDLE: if (r0_vld | r1_vld) begin
        state_d   = ISSUE;
        owner_d   = grant;
        cmd_d     = grant ? r1_cmd : r0_cmd;
        is_read_d = ~cmd_d[CMD_WIDTH-1];
        rdata_d   = '0;
        err_d     = 1'b0;
      end
      ISSUE: if (m_cmd_rdy) begin
        state_d = WAIT_START;
        cnt_d   = '0;
      end
      // counter saturates so a late WAIT_START exit cannot restart the timeout window
      WAIT_START: begin
        cnt_d = tmo ? cnt_q : cnt_q + 1'b1;
        if (!m_cmd_rdy) state_d = WAIT_DONE;
        else if (tmo) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      WAIT_DONE: begin
        cnt_d = tmo ? cnt_q : cnt_q + 1'b1;
        if (exit_c) begin
          state_d = DONE;
          rdata_d = is_read_q ? m_read_data : '0;
        end else if (tmo) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    m_cmd_vld  = state_q == ISSUE;
    m_cmd_data = cmd_q;
    busy       = state_q != IDLE;
    owner      = owner_q;
    r0_rdy     = rst_n & (state_q == IDLE) & r0_vld & ~grant;
    r1_rdy     = rst_n & (state_q == IDLE) & r1_vld & grant;
    r0_done    = (state_q == DONE) & ~owner_q;
    r1_done    = (state_q == DONE) & owner_q;
    r0_err     = r0_done & err_q;
    r1_err     = r1_done & err_q;
    r0_rd_data = r0_done ? rdata_q : '0;
    r1_rd_data = r1_done ? rdata_q : '0;
  end
endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// tb_spi_cmd_arbiter: scoreboard bench for spi_cmd_arbiter with a behavioural SPI master.
module tb_spi_cmd_arbiter;
  typedef struct {logic own; logic err; logic [7:0] d;} exp_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [11:0] r0_cmd, r1_cmd, m_cmd_data;
  logic r0_vld, r1_vld, r0_rdy, r1_rdy, r0_done, r1_done, r0_err, r1_err;
  logic [7:0] r0_rd_data, r1_rd_data;
  logic [7:0] m_read_data = 8'h00;
  logic m_cmd_vld, busy, owner;
  logic m_cmd_rdy = 1'b0;
  logic m_read_vld = 1'b0;
  exp_t sb[$];
  int tests = 0, fails = 0, cyc = 0, ndone = 0, t_acc = 0;
  int busy_len = 4, left = 0, hs = 0;
  logic m_hold = 1'b0, took = 1'b0, mst_rd = 1'b0;
  logic [7:0] rdata = 8'h00;
  logic [11:0] hs_cmd = 12'h000;

  spi_cmd_arbiter #(.CMD_WIDTH(12), .READ_WIDTH(8), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_cmd(r0_cmd), .r0_vld(r0_vld), .r0_rdy(r0_rdy), .r0_done(r0_done), .r0_err(r0_err), .r0_rd_data(r0_rd_data),
    .r1_cmd(r1_cmd), .r1_vld(r1_vld), .r1_rdy(r1_rdy), .r1_done(r1_done), .r1_err(r1_err), .r1_rd_data(r1_rd_data),
    .m_cmd_data(m_cmd_data), .m_cmd_vld(m_cmd_vld), .m_cmd_rdy(m_cmd_rdy),
    .m_read_vld(m_read_vld), .m_read_data(m_read_data), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // master: takes a command, drops rdy for busy_len cycles, then raises rdy (and pulses read data for reads)
  always @(negedge clk) begin
    m_read_vld = 1'b0;
    if (!rst_n) begin
      took = 1'b0;
      left = 0;
    end else if (took) begin
      took = 1'b0;
      left = busy_len;
    end else if (left > 0) begin
      left--;
      if (left == 0 && mst_rd) begin
        m_read_vld  = 1'b1;
        m_read_data = rdata;
      end
    end
    m_cmd_rdy = left == 0 && !took && !m_hold;
    if (rst_n && m_cmd_vld && m_cmd_rdy) begin
      took   = 1'b1;
      mst_rd = !m_cmd_data[11];
      hs_cmd = m_cmd_data;
      hs++;
    end
  end

  task automatic tick();
    exp_t e;
    logic [19:0] got, want;
    @(posedge clk);
    #1;
    cyc++;
    tests++;
    if ((r0_rdy && r1_rdy) || ((r0_rdy || r1_rdy) && busy)) begin
      fails++;
      $display("FAIL rdy_rule: r0_rdy=%b r1_rdy=%b busy=%b (need at most one, only when idle)", r0_rdy, r1_rdy, busy);
    end
    if (r0_done || r1_done) begin
      ndone++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL spurious_done: r0_done=%b r1_done=%b with nothing outstanding", r0_done, r1_done);
      end else begin
        e = sb.pop_front();
        got  = {r1_done, r0_done, r1_err, r0_err, r1_rd_data, r0_rd_data};
        want = {e.own, !e.own, e.own & e.err, !e.own & e.err, e.own ? e.d : 8'h00, e.own ? 8'h00 : e.d};
        if (got !== want) begin
          fails++;
          $display("FAIL done_payload: got %h expected %h at cycle %0d", got, want, cyc);
        end
      end
    end
  endtask

  task automatic send(input logic r, input logic [11:0] c, input logic err, input logic [7:0] d);
    int n = 0;
    if (r) begin r1_cmd = c; r1_vld = 1'b1; end
    else begin r0_cmd = c; r0_vld = 1'b1; end
    #1;
    while (!(r ? r1_rdy : r0_rdy) && n < 50) begin
      tick();
      n++;
    end
    tests++;
    if (n >= 50) begin
      fails++;
      $display("FAIL accept_timeout: requester %0d not accepted in %0d cycles", r, n);
    end else sb.push_back('{r, err, d});
    tick();
    t_acc = cyc;
    r0_vld = 1'b0;
    r1_vld = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_cyc);
    int start = ndone;
    int n = 0;
    while (ndone == start && n < 200) begin
      tick();
      n++;
    end
    tests++;
    if (ndone == start) begin
      fails++;
      $display("FAIL %s_timeout: no done after %0d cycles", name, n);
    end else if (cyc != exp_cyc) begin
      fails++;
      $display("FAIL %s_latency: done at cycle %0d, expected %0d", name, cyc, exp_cyc);
    end
  endtask

  task automatic test_reset();
    logic [36:0] got;
    rst_n = 1'b0;
    r0_vld = 1'b1; r1_vld = 1'b1; r0_cmd = 12'hFFF; r1_cmd = 12'h7FF;
    repeat (3) tick();
    got = {owner, busy, m_cmd_vld, r0_rdy, r1_rdy, r0_done, r1_done, r0_err, r1_err, m_cmd_data, r0_rd_data, r1_rd_data};
    tests++;
    if (got !== {1'b1, 36'h0}) begin
      fails++;
      $display("FAIL reset_state: got %h expected %h", got, {1'b1, 36'h0});
    end
    r0_vld = 1'b0; r1_vld = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    int h0 = hs;
    busy_len = 12;
    send(1'b0, 12'h8A5, 1'b0, 8'h00);
    tests++;
    if (m_cmd_vld !== 1'b1 || m_cmd_data !== 12'h8A5) begin
      fails++;
      $display("FAIL write_issue: vld=%b data=%h expected 1/8a5", m_cmd_vld, m_cmd_data);
    end
    wait_done("write", t_acc + 14);
    tests++;
    if (hs - h0 != 1 || hs_cmd !== 12'h8A5) begin
      fails++;
      $display("FAIL write_handshake: count=%0d cmd=%h expected 1/8a5", hs - h0, hs_cmd);
    end
    tests++;
    if (owner !== 1'b0) begin
      fails++;
      $display("FAIL write_owner: got %b expected 0", owner);
    end
  endtask

  task automatic test_read();
    busy_len = 5;
    rdata = 8'h5A;
    send(1'b1, 12'h03C, 1'b0, 8'h5A);
    wait_done("read", t_acc + 7);
    tests++;
    if (owner !== 1'b1) begin
      fails++;
      $display("FAIL read_owner: got %b expected 1", owner);
    end
  endtask

  task automatic test_contention();
    int n0 = 4, n1 = 4, lim = 0;
    logic lastg = 1'b1;
    logic g, expg;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    sb.delete();
    busy_len = 2;
    rdata = 8'h3C;
    while ((n0 > 0 || n1 > 0 || sb.size() > 0) && lim < 500) begin
      tick();
      lim++;
      r0_vld = n0 > 0; r1_vld = n1 > 0;
      r0_cmd = {8'h80, 4'(n0)}; r1_cmd = {8'h01, 4'(n1)};
      #1;
      if (r0_rdy || r1_rdy) begin
        g = r1_rdy;
        expg = (n0 > 0 && n1 > 0) ? ~lastg : (n1 > 0);
        tests++;
        if (g !== expg) begin
          fails++;
          $display("FAIL grant_order: granted r%0d expected r%0d (r0 left %0d, r1 left %0d)", g, expg, n0, n1);
        end
        sb.push_back('{g, 1'b0, g ? 8'h3C : 8'h00});
        lastg = g;
        if (g) n1--; else n0--;
      end
    end
    tests++;
    if (lim >= 500) begin
      fails++;
      $display("FAIL contention_timeout: r0 left %0d r1 left %0d pending %0d", n0, n1, sb.size());
    end
    r0_vld = 1'b0; r1_vld = 1'b0;
  endtask

  task automatic test_timeout();
    busy_len = 25;
    rdata = 8'hEE;
    send(1'b0, 12'h055, 1'b1, 8'h00);
    wait_done("read_timeout", t_acc + 17);
    repeat (20) tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL late_read_busy: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_timeout_boundary();
    busy_len = 15;
    send(1'b1, 12'h9AB, 1'b0, 8'h00);
    wait_done("exit_wins", t_acc + 17);
    busy_len = 16;
    send(1'b1, 12'h9CD, 1'b1, 8'h00);
    wait_done("write_timeout", t_acc + 17);
    repeat (3) tick();
  endtask

  task automatic test_backpressure();
    m_hold = 1'b1;
    busy_len = 3;
    send(1'b0, 12'h9F0, 1'b0, 8'h00);
    repeat (20) begin
      tick();
      tests++;
      if (m_cmd_vld !== 1'b1 || m_cmd_data !== 12'h9F0 || r0_done || r1_done || busy !== 1'b1) begin
        fails++;
        $display("FAIL backpressure_hold: vld=%b data=%h done=%b%b busy=%b expected 1/9f0/00/1", m_cmd_vld, m_cmd_data, r1_done, r0_done, busy);
      end
    end
    m_hold = 1'b0;
    wait_done("backpressure", cyc + 5);
  endtask

  task automatic test_reset_mid_read();
    logic [36:0] got;
    busy_len = 20;
    rdata = 8'h77;
    send(1'b0, 12'h0AA, 1'b0, 8'h77);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    got = {owner, busy, m_cmd_vld, r0_rdy, r1_rdy, r0_done, r1_done, r0_err, r1_err, m_cmd_data, r0_rd_data, r1_rd_data};
    tests++;
    if (got !== {1'b1, 36'h0}) begin
      fails++;
      $display("FAIL reset_mid_read: got %h expected %h", got, {1'b1, 36'h0});
    end
    sb.delete();
    rst_n = 1'b1;
    repeat (25) tick();
    busy_len = 4;
    send(1'b1, 12'hA11, 1'b0, 8'h00);
    wait_done("post_reset_write", t_acc + 6);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_timeout();
    test_timeout_boundary();
    test_backpressure();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
